// File: rtl/issue_queue.sv
// Out-of-order issue queue: age-matrix oldest-ready select,
// wakeup/bypass of source readiness, branch-mispredict flush.
`timescale 1ns/1ps

package iq_pkg;
  typedef struct packed {
    logic       valid;
    logic [5:0] idx;
    logic       ready;
  } src_t;

  typedef struct packed {
    logic valid;
    src_t rd;
    src_t rs1;
    src_t rs2;
  } rinstr_t;

  typedef struct packed {
    logic       valid;
    logic [5:0] idx;
  } p_reg_t;

  typedef struct packed {
    logic valid;
    logic hit;
  } br_result_t;
endpackage

module issue_queue
  import iq_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  rinstr_t                  rinstr_i,
  input  p_reg_t                   wakeup_i,
  input  br_result_t               br_result_i,
  input  logic                     issue_ready_i,
  output rinstr_t                  issued_o,
  output logic                     iq_full_o,
  output logic [$clog2(DEPTH):0]   occ_o
);

  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] rdy1_q, rdy1_d;
  logic [DEPTH-1:0] rdy2_q, rdy2_d;
  // age_q[i][j] set means entry i is older than entry j
  logic [DEPTH-1:0] age_q [DEPTH];
  logic [DEPTH-1:0] age_d [DEPTH];
  rinstr_t          instr_q [DEPTH];

  logic [DEPTH-1:0] elig;
  logic [DEPTH-1:0] blk;
  logic [DEPTH-1:0] sel;
  logic [DEPTH-1:0] free_oh;
  logic             free_fnd;
  logic             flush;
  logic             enq;
  logic             deq;
  rinstr_t          issued;
  logic [AW:0]      occ;

  function automatic logic src_rdy(src_t s, p_reg_t w);
    return s.ready || !s.valid || (s.idx == 6'd0) ||
           (w.valid && (w.idx == s.idx));
  endfunction

  assign flush = br_result_i.valid && !br_result_i.hit;

  always_comb begin
    elig = valid_q & rdy1_q & rdy2_q;
    blk  = '0;
    sel  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      for (int j = 0; j < DEPTH; j++) begin
        if (elig[j] && age_q[j][i]) blk[i] = 1'b1;
      end
      sel[i] = elig[i] && !blk[i];
    end
  end

  always_comb begin
    issued = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (sel[i]) issued = instr_q[i];
    end
    issued.valid = |sel;
    if (issued.rs1.valid) issued.rs1.ready = 1'b1;
    if (issued.rs2.valid) issued.rs2.ready = 1'b1;
  end

  always_comb begin
    free_oh  = '0;
    free_fnd = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!valid_q[i] && !free_fnd) begin
        free_oh[i] = 1'b1;
        free_fnd   = 1'b1;
      end
    end
  end

  always_comb begin
    occ = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occ = occ + {{AW{1'b0}}, valid_q[i]};
    end
  end

  assign iq_full_o = &valid_q;
  assign occ_o     = occ;
  assign issued_o  = issued;

  assign enq = rinstr_i.valid && !iq_full_o && !flush;
  assign deq = issued.valid && issue_ready_i && !flush;

  always_comb begin
    valid_d = valid_q;
    rdy1_d  = rdy1_q;
    rdy2_d  = rdy2_q;
    age_d   = age_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (wakeup_i.valid && valid_q[i]) begin
        if (instr_q[i].rs1.idx == wakeup_i.idx) rdy1_d[i] = 1'b1;
        if (instr_q[i].rs2.idx == wakeup_i.idx) rdy2_d[i] = 1'b1;
      end
    end
    if (deq) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (sel[i]) begin
          valid_d[i] = 1'b0;
          age_d[i]   = '0;
          for (int j = 0; j < DEPTH; j++) age_d[j][i] = 1'b0;
        end
      end
    end
    if (enq) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (free_oh[i]) begin
          valid_d[i] = 1'b1;
          rdy1_d[i]  = src_rdy(rinstr_i.rs1, wakeup_i);
          rdy2_d[i]  = src_rdy(rinstr_i.rs2, wakeup_i);
          age_d[i]   = '0;
          for (int j = 0; j < DEPTH; j++) begin
            age_d[j][i] = valid_q[j] && !(deq && sel[j]);
          end
        end
      end
    end
    if (flush) begin
      valid_d = '0;
      for (int i = 0; i < DEPTH; i++) age_d[i] = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
      rdy1_q  <= '0;
      rdy2_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        age_q[i]   <= '0;
        instr_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      rdy1_q  <= rdy1_d;
      rdy2_q  <= rdy2_d;
      for (int i = 0; i < DEPTH; i++) begin
        age_q[i] <= age_d[i];
        if (enq && free_oh[i]) instr_q[i] <= rinstr_i;
      end
    end
  end

endmodule

// File: tb/tb_issue_queue.sv
// Scoreboard bench for issue_queue: directed vectors push expected
// issues; a negedge monitor pops and compares every accepted issue.
`timescale 1ns/1ps

module tb_issue_queue;
  import iq_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  rinstr_t    rinstr = '0;
  p_reg_t     wakeup = '0;
  br_result_t br = '0;
  logic       issue_rdy = 1'b0;
  rinstr_t    issued;
  logic       full;
  logic [3:0] occ;

  int vecs = 0;
  int errs = 0;
  rinstr_t exp_q[$];

  issue_queue #(.DEPTH(8)) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .rinstr_i(rinstr),
    .wakeup_i(wakeup),
    .br_result_i(br),
    .issue_ready_i(issue_rdy),
    .issued_o(issued),
    .iq_full_o(full),
    .occ_o(occ)
  );

  always #5 clk = ~clk;

  function automatic rinstr_t mk(
    logic [5:0] tag,
    logic v1, logic [5:0] i1, logic r1,
    logic v2, logic [5:0] i2, logic r2);
    rinstr_t r;
    r.valid     = 1'b1;
    r.rd.valid  = 1'b1;
    r.rd.idx    = tag;
    r.rd.ready  = 1'b0;
    r.rs1.valid = v1;
    r.rs1.idx   = i1;
    r.rs1.ready = r1;
    r.rs2.valid = v2;
    r.rs2.idx   = i2;
    r.rs2.ready = r2;
    return r;
  endfunction

  // Monitor: value on issued_o at an accepting edge must match head
  always @(negedge clk) begin
    if (rst_n && issued.valid && issue_rdy && !(br.valid && !br.hit)) begin
      vecs++;
      if (exp_q.size() == 0) begin
        errs++;
        $display("FAIL unexpected_issue got=%h", issued);
      end else begin
        rinstr_t e;
        e = exp_q.pop_front();
        if (issued !== e) begin
          errs++;
          $display("FAIL issue_order got=%h want=%h", issued, e);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string nm, int got, int want);
    vecs++;
    if (got != want) begin
      errs++;
      $display("FAIL %s got=%0d want=%0d", nm, got, want);
    end
  endtask

  initial begin
    // reset state
    #12;
    chk("rst_occ", occ, 0);
    chk("rst_full", full, 0);
    chk("rst_issued", (issued == '0) ? 1 : 0, 1);
    cyc();
    rst_n = 1'b1;
    cyc();

    // wakeup makes waiting instr eligible
    issue_rdy = 1'b1;
    rinstr = mk(6'd1, 1, 6'd33, 0, 0, 6'd0, 0);
    cyc();
    rinstr = '0;
    chk("wait_occ", occ, 1);
    chk("wait_novalid", issued.valid, 0);
    wakeup = '{valid: 1'b1, idx: 6'd33};
    exp_q.push_back(mk(6'd1, 1, 6'd33, 1, 0, 6'd0, 0));
    cyc();
    wakeup = '0;
    chk("woken_valid", issued.valid, 1);
    cyc();
    chk("woken_occ", occ, 0);

    // age order A,B,C
    issue_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rinstr = mk(6'(2 + i), 1, 6'd5, 1, 1, 6'd6, 1);
      exp_q.push_back(mk(6'(2 + i), 1, 6'd5, 1, 1, 6'd6, 1));
      cyc();
    end
    rinstr = '0;
    chk("abc_occ3", occ, 3);
    issue_rdy = 1'b1;
    cyc();
    chk("abc_occ2", occ, 2);
    cyc();
    chk("abc_occ1", occ, 1);
    cyc();
    chk("abc_occ0", occ, 0);

    // fill, overflow ignored, wakeup drains oldest-first
    issue_rdy = 1'b0;
    for (int i = 0; i < 8; i++) begin
      rinstr = mk(6'(10 + i), 1, 6'd40, 0, 0, 6'd0, 0);
      cyc();
    end
    chk("fill_full", full, 1);
    chk("fill_occ", occ, 8);
    rinstr = mk(6'd18, 1, 6'd7, 1, 0, 6'd0, 0);
    cyc();
    rinstr = '0;
    chk("ovf_occ", occ, 8);
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(mk(6'(10 + i), 1, 6'd40, 1, 0, 6'd0, 0));
    end
    wakeup = '{valid: 1'b1, idx: 6'd40};
    issue_rdy = 1'b1;
    cyc();
    wakeup = '0;
    chk("drain_full_held", full, 1);
    cyc();
    chk("drain_full_drop", full, 0);
    chk("drain_occ7", occ, 7);
    repeat (7) cyc();
    chk("drain_occ0", occ, 0);

    // same-cycle wakeup bypass; idx 0 counts as ready
    rinstr = mk(6'd20, 1, 6'd45, 0, 0, 6'd0, 0);
    wakeup = '{valid: 1'b1, idx: 6'd45};
    exp_q.push_back(mk(6'd20, 1, 6'd45, 1, 0, 6'd0, 0));
    cyc();
    wakeup = '0;
    rinstr = mk(6'd21, 0, 6'd9, 0, 1, 6'd0, 0);
    exp_q.push_back(mk(6'd21, 0, 6'd9, 0, 1, 6'd0, 1));
    chk("bypass_valid", issued.valid, 1);
    cyc();
    rinstr = '0;
    cyc();
    chk("bypass_occ", occ, 0);

    // hit has no effect, mispredict flushes everything
    issue_rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      rinstr = mk(6'(30 + i), 1, 6'd1, 1, 0, 6'd0, 0);
      cyc();
    end
    rinstr = '0;
    br = '{valid: 1'b1, hit: 1'b1};
    cyc();
    br = '0;
    chk("hit_occ", occ, 5);
    br = '{valid: 1'b1, hit: 1'b0};
    rinstr = mk(6'd35, 1, 6'd1, 1, 0, 6'd0, 0);
    issue_rdy = 1'b1;
    cyc();
    br = '0;
    rinstr = '0;
    chk("flush_occ", occ, 0);
    chk("flush_novalid", issued.valid, 0);
    repeat (3) cyc();
    chk("flush_occ_stay", occ, 0);

    // asynchronous reset mid-operation
    issue_rdy = 1'b0;
    for (int i = 0; i < 6; i++) begin
      rinstr = mk(6'(40 + i), 1, 6'd2, 1, 0, 6'd0, 0);
      exp_q.push_back(mk(6'(40 + i), 1, 6'd2, 1, 0, 6'd0, 0));
      cyc();
    end
    rinstr = '0;
    chk("pre_rst_occ", occ, 6);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_occ", occ, 0);
    chk("arst_full", full, 0);
    chk("arst_issued", (issued == '0) ? 1 : 0, 1);
    exp_q.delete();
    cyc();
    cyc();
    rst_n = 1'b1;
    rinstr = mk(6'd50, 1, 6'd3, 1, 0, 6'd0, 0);
    exp_q.push_back(mk(6'd50, 1, 6'd3, 1, 0, 6'd0, 0));
    issue_rdy = 1'b1;
    cyc();
    rinstr = '0;
    chk("post_rst_occ", occ, 1);
    cyc();
    chk("post_rst_drain", occ, 0);

    repeat (2) cyc();
    chk("sb_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/issue_queue.md
ISSUE_QUEUE -- requirements
Module: issue_queue

Interface
REQ-001 SHALL provide parameter DEPTH, default 8, number of queue entries (power of two, 2..16).
REQ-002 SHALL provide port clk_i  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL provide port rst_ni  input  1  reset; one clock, reset asynchronous and active-low.
REQ-004 SHALL provide port rinstr_i  input  rinstr_t  renamed instruction from rename stage (valid, rd/rs1/rs2 each {valid, idx[5:0], ready}).
REQ-005 SHALL provide port wakeup_i  input  p_reg_t  physical-register writeback broadcast (valid, idx[5:0]).
REQ-006 SHALL provide port br_result_i  input  br_result_t  branch resolution (valid, hit); valid && !hit means flush.
REQ-007 SHALL provide port issue_ready_i  input  1  execute stage accepts issued_o this cycle.
REQ-008 SHALL provide port issued_o  output  rinstr_t  selected instruction for issue.
REQ-009 SHALL provide port iq_full_o  output  1  all DEPTH entries occupied; upstream must hold.
REQ-010 SHALL provide port occ_o  output  $clog2(DEPTH)+1  number of occupied entries.

Function
REQ-011 SHALL hold per entry: valid bit, full rinstr_t payload, per-source ready bits, and an age relation to every other entry (age matrix or equivalent).
REQ-012 Enqueue SHALL occur at the rising edge when rinstr_i.valid && !iq_full_o, writing the lowest-index free entry; that entry becomes younger than all occupied entries.
REQ-013 rinstr_i presented while iq_full_o=1 SHALL be ignored; iq_full_o and occ_o SHALL be derived from registered state only (no same-cycle credit from a dequeue).
REQ-014 On enqueue, a source SHALL be stored ready if rinstr_i source ready=1, or source valid=0, or source idx=0, or wakeup_i.valid with wakeup_i.idx equal to that source idx in the same cycle (bypass).
REQ-015 Each cycle wakeup_i.valid SHALL set the ready bit of every occupied entry source whose idx equals wakeup_i.idx, effective from the next edge.
REQ-016 An entry SHALL be eligible when valid and all of its valid sources are ready; issued_o SHALL carry the oldest eligible entry combinationally from registered state, with rs1/rs2 ready fields forced to 1 for valid sources; issued_o.valid=0 if none is eligible.
REQ-017 Minimum latency SHALL be one cycle: an instruction enqueued with ready sources at edge N appears on issued_o in cycle N..N+1 and never in the same cycle as enqueue.
REQ-018 Dequeue SHALL occur at the edge where issued_o.valid && issue_ready_i; that entry is freed and removed from the age relation.
REQ-019 While issue_ready_i=0, issued_o MAY change to an older entry that became eligible; only the value present at the accepting edge is dequeued.
REQ-020 Simultaneous enqueue and dequeue SHALL be legal; occ_o updates by +1, -1 or 0 accordingly and never exceeds DEPTH.
REQ-021 br_result_i.valid && !br_result_i.hit SHALL invalidate all entries at that edge; flush takes priority over a same-cycle enqueue (dropped) and dequeue (counts as not issued); occ_o=0 next cycle.
REQ-022 br_result_i.valid && hit SHALL have no effect on queue state.

Reset
REQ-023 While rst_ni=0, all entry valid bits, ready bits and age state SHALL clear asynchronously; issued_o='0, iq_full_o=0, occ_o=0.
REQ-024 Reset asserted mid-operation SHALL discard all entries with no dequeue; first enqueue SHALL be accepted at the first rising edge after rst_ni rises.

Verification
REQ-025 Enqueue instr A (rs1 p33 not ready, rs2 invalid) -> issued_o.valid=0; drive wakeup_i idx=33 -> A on issued_o next cycle with rs1.ready=1.
REQ-026 Enqueue A, B, C all ready with issue_ready_i=0, then hold issue_ready_i=1 -> issue order A, B, C, occ_o 3->2->1->0.
REQ-027 Fill 8 entries with sources waiting on p40 -> iq_full_o=1, 9th instruction ignored, occ_o=8; wakeup idx=40 plus issue_ready_i=1 -> 8 oldest-first issues, iq_full_o drops after first dequeue.
REQ-028 Enqueue instr with rs1=p45 in same cycle as wakeup_i idx=45 -> entry stored ready, issued next cycle.
REQ-029 Occupancy 5, flush (br valid, hit=0) with simultaneous enqueue and accepted issue -> occ_o=0 next cycle, issued_o.valid=0, dropped enqueue never issues.
REQ-030 Assert rst_ni=0 asynchronously with occ_o=6 -> outputs zero immediately, no dequeue recorded, enqueue accepted on first edge after release.
